dmem_pipelined: RTL and testbench

DMEM_PIPELINED -- requirements
Module: dmem_pipelined

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_pipelined.sv | 156 +++++++++++++++
 tb/tb_dmem_pipelined.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg : shared types and constants for the pipelined data memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } dmem_state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array : single-port DEPTH x DATA_W storage, sync write, registered read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_array #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 65536,
   parameter int IDX_W  = 16
) (
   input  logic              clk,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_addr] <= i_wdata;
         end else begin
            o_rdata <= r_mem[i_addr];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_pipelined.sv
// ---------------------------------------------------------------------------
// dmem_pipelined : data memory with READ_LAT load pipeline, range check and
//                  hardware clear sequence (also run automatically after reset)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_pipelined
   import dmem_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int DEPTH    = 65536,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   input  logic              clear_req,
   output logic              clear_done
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   generate
      if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
         $error("dmem_pipelined: READ_LAT out of range");
      end
   endgenerate

   dmem_state_e       r_state;
   dmem_state_e       w_state_nxt;
   logic [IDX_W-1:0]  r_clr_cnt;
   logic              w_in_range;
   logic              w_acc;
   logic              w_acc_ld;
   logic              w_acc_st;
   logic              w_last_clr;
   logic              w_arr_en;
   logic              w_arr_we;
   logic [IDX_W-1:0]  w_arr_addr;
   logic [DATA_W-1:0] w_arr_wdata;
   logic [DATA_W-1:0] w_arr_rdata;
   logic [READ_LAT-1:0] r_vld;
   logic [READ_LAT-1:0] r_err;
   logic [DATA_W-1:0] w_dat [READ_LAT];

   assign w_in_range = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));
   assign req_ready  = (r_state == IDLE);
   assign clear_done = (r_state == DONE);
   // clear_req wins over a request presented in the same cycle
   assign w_acc      = req_ready & req_valid & ~clear_req;
   assign w_acc_ld   = w_acc & ~req_we;
   assign w_acc_st   = w_acc & req_we & w_in_range;
   assign w_last_clr = (r_clr_cnt == IDX_W'(DEPTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (clear_req) w_state_nxt = CLEAR;
         CLEAR:   if (w_last_clr) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clr_cnt <= '0;
      end else if (r_state == CLEAR && !w_last_clr) begin
         r_clr_cnt <= r_clr_cnt + 1'b1;
      end else begin
         r_clr_cnt <= '0;
      end
   end

   always_comb begin
      w_arr_en    = 1'b0;
      w_arr_we    = 1'b0;
      w_arr_addr  = req_addr[IDX_W-1:0];
      w_arr_wdata = req_wdata;
      if (r_state == CLEAR) begin
         w_arr_en    = 1'b1;
         w_arr_we    = 1'b1;
         w_arr_addr  = r_clr_cnt;
         w_arr_wdata = '0;
      end else if (w_acc_ld) begin
         w_arr_en = w_in_range;
      end else if (w_acc_st) begin
         w_arr_en = 1'b1;
         w_arr_we = 1'b1;
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .i_en    (w_arr_en),
      .i_we    (w_arr_we),
      .i_addr  (w_arr_addr),
      .i_wdata (w_arr_wdata),
      .o_rdata (w_arr_rdata)
   );

   // Stage 0 is the array's own read register; later stages only delay it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_err <= '0;
      end else begin
         r_vld[0] <= w_acc_ld;
         r_err[0] <= w_acc_ld & ~w_in_range;
         for (int i = 1; i < READ_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_err[i] <= r_err[i-1];
         end
      end
   end

   assign w_dat[0] = w_arr_rdata;

   generate
      for (genvar g = 1; g < READ_LAT; g++) begin : g_dat_stage
         logic [DATA_W-1:0] r_dat;
         always_ff @(posedge clk) begin
            r_dat <= w_dat[g-1];
         end
         assign w_dat[g] = r_dat;
      end
   endgenerate

   assign rsp_valid = r_vld[READ_LAT-1];
   assign rsp_err   = r_vld[READ_LAT-1] & r_err[READ_LAT-1];
   assign rsp_rdata = (r_vld[READ_LAT-1] & ~r_err[READ_LAT-1]) ? w_dat[READ_LAT-1] : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_pipelined.sv
// ---------------------------------------------------------------------------
// tb_dmem_pipelined : directed + random bench against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_pipelined;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 16;
   localparam int RL     = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              clear_req = 1'b0;
   logic              clear_done;

   dmem_pipelined #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .READ_LAT (RL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .clear_req  (clear_req),
      .clear_done (clear_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_left = clock edges still to go before the memory accepts requests again.
   // A load accepted at edge k is visible on the outputs after edge k+RL-1,
   // so a consumer sampling on rising edges sees it at edge k+RL.
   typedef struct {int due; logic [15:0] data; logic err;} exp_t;
   typedef struct {logic [15:0] data; logic err; int cyc;} got_t;

   logic [15:0] mm [DEPTH];
   exp_t        mq [$];
   got_t        got_q [$];
   int          cyc = 0;
   int          m_left = DEPTH + 1;
   int          done_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_left = DEPTH + 1;
         foreach (mm[i]) mm[i] = '0;
      end else begin
         cyc++;
         if (m_left > 0) begin
            m_left--;
         end else if (clear_req) begin
            m_left = DEPTH + 1;
            foreach (mm[i]) mm[i] = '0;
         end else if (req_valid) begin
            if (req_we) begin
               if (req_addr < DEPTH) mm[req_addr[3:0]] = req_wdata;
            end else begin
               exp_t e;
               e.due  = cyc + RL - 1;
               e.data = (req_addr < DEPTH) ? mm[req_addr[3:0]] : 16'h0000;
               e.err  = (req_addr >= DEPTH);
               mq.push_back(e);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic        ev;
      logic [15:0] ed;
      logic        ee;
      ev = 1'b0;
      ed = '0;
      ee = 1'b0;
      if (mq.size() > 0 && mq[0].due == cyc) begin
         ev = 1'b1;
         ed = mq[0].data;
         ee = mq[0].err;
         void'(mq.pop_front());
      end
      check("req_ready",  32'(req_ready),  32'(m_left == 0));
      check("clear_done", 32'(clear_done), 32'(m_left == 1));
      check("rsp_valid",  32'(rsp_valid),  32'(ev));
      check("rsp_rdata",  32'(rsp_rdata),  32'(ed));
      check("rsp_err",    32'(rsp_err),    32'(ee));
      if (rsp_valid) begin
         got_t g;
         g.data = rsp_rdata;
         g.err  = rsp_err;
         g.cyc  = cyc;
         got_q.push_back(g);
      end
      if (clear_done) done_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   int last_cyc;

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic op(input logic we, input logic [15:0] a, input logic [15:0] d,
                     input logic clr);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      clear_req = clr;
      @(posedge clk);
      #1;
      last_cyc  = cyc;
      req_valid = 1'b0;
      req_we    = 1'b0;
      clear_req = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!req_ready) begin
         errors++;
         $display("FAIL wait_ready: timed out after %0d cycles", n);
      end
   endtask

   task automatic load_all();
      for (int i = 0; i < DEPTH; i++) op(1'b0, 16'(i), 16'h0, 1'b0);
      idle(RL + 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      got_t g;

      idle(3);
      check("reset_ready", 32'(req_ready), 32'h0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'h0);

      // Reset release: ready after DEPTH+1 edges, one clear_done pulse
      done_cnt = 0;
      rst_n = 1'b1;
      wait_ready(n);
      check("ready_latency", 32'(n), 32'd17);
      check("clear_done_pulses", 32'(done_cnt), 32'd1);
      load_all();
      got_q.delete();

      // Store then immediate load at READ_LAT=3
      op(1'b1, 16'd5, 16'hBEEF, 1'b0);
      op(1'b0, 16'd5, 16'h0, 1'b0);
      n = last_cyc;
      idle(RL + 2);
      check("raw_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) begin
         g = got_q.pop_front();
         check("raw_data", 32'(g.data), 32'hBEEF);
         check("raw_err", 32'(g.err), 32'h0);
         check("raw_latency", 32'(g.cyc - n + 1), 32'd3);
      end

      // Back-to-back loads return in order on consecutive cycles
      op(1'b1, 16'd1, 16'h1111, 1'b0);
      op(1'b1, 16'd2, 16'h2222, 1'b0);
      op(1'b1, 16'd3, 16'h3333, 1'b0);
      got_q.delete();
      op(1'b0, 16'd1, 16'h0, 1'b0);
      op(1'b0, 16'd2, 16'h0, 1'b0);
      op(1'b0, 16'd3, 16'h0, 1'b0);
      idle(RL + 2);
      check("b2b_count", 32'(got_q.size()), 32'd3);
      if (got_q.size() == 3) begin
         check("b2b_data0", 32'(got_q[0].data), 32'h1111);
         check("b2b_data1", 32'(got_q[1].data), 32'h2222);
         check("b2b_data2", 32'(got_q[2].data), 32'h3333);
         check("b2b_gap", 32'(got_q[2].cyc - got_q[0].cyc), 32'd2);
      end
      got_q.delete();

      // Out-of-range load and store
      op(1'b0, 16'h0010, 16'h0, 1'b0);
      idle(RL + 2);
      check("oor_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) begin
         g = got_q.pop_front();
         check("oor_data", 32'(g.data), 32'h0);
         check("oor_err", 32'(g.err), 32'h1);
      end
      op(1'b1, 16'h0020, 16'hAAAA, 1'b0);
      load_all();
      got_q.delete();

      // Load colliding with clear_req is dropped; clear zeroes the array
      op(1'b1, 16'd7, 16'h1234, 1'b0);
      op(1'b0, 16'd7, 16'h0, 1'b1);
      idle(RL + 2);
      check("clr_load_dropped", 32'(got_q.size()), 32'd0);
      wait_ready(n);
      op(1'b0, 16'd7, 16'h0, 1'b0);
      idle(RL + 2);
      check("clr_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) begin
         g = got_q.pop_front();
         check("clr_data", 32'(g.data), 32'h0);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_we    = $urandom_range(0, 1) != 0;
         req_addr  = 16'($urandom_range(0, 19));
         req_wdata = 16'($urandom);
         clear_req = ($urandom_range(0, 96) == 0);
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      clear_req = 1'b0;
      wait_ready(n);
      load_all();

      // Reset mid-read discards the in-flight response
      op(1'b1, 16'd4, 16'h5A5A, 1'b0);
      got_q.delete();
      op(1'b0, 16'd4, 16'h0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midread_rsp_valid", 32'(rsp_valid), 32'h0);
      idle(RL + 2);
      check("midread_discard", 32'(got_q.size()), 32'd0);
      rst_n = 1'b1;
      wait_ready(n);
      check("midread_ready_latency", 32'(n), 32'd17);

      // Reset mid-clear at clr_cnt = 8 restarts the full clear
      op(1'b1, 16'd9, 16'hC0DE, 1'b0);
      op(1'b0, 16'd0, 16'h0, 1'b1);
      idle(8);
      rst_n = 1'b0;
      #1;
      check("midclr_ready", 32'(req_ready), 32'h0);
      check("midclr_done", 32'(clear_done), 32'h0);
      check("midclr_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'h0);
      idle(2);
      rst_n = 1'b1;
      done_cnt = 0;
      wait_ready(n);
      check("midclr_ready_latency", 32'(n), 32'd17);
      check("midclr_done_pulses", 32'(done_cnt), 32'd1);
      load_all();

      idle(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
